// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace chunk sequencer and its dispatcher.
package trace_pkg;

   typedef enum logic [1:0] {
      D_IDLE,
      D_START,
      D_WAIT
   } disp_state_t;

   localparam int BPW = 32 / 8;

   function automatic int half_depth(input int addr_width);
      return 1 << (addr_width - 1);
   endfunction

endpackage

// File: rtl/trace_chunk_dispatch.sv
// Hands sealed buffer halves to the AXI write engine in seal order and tracks
// how many words of the DRAM region have been written so far.
module trace_chunk_dispatch
   import trace_pkg::*;
#(
   parameter int AddrWidth    = 10,
   parameter int AxiAddrWidth = 64,
   parameter int WordBytes    = BPW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_load,
   input  logic [1:0]              pend,
   input  logic [AddrWidth-1:0]    size_lo,
   input  logic [AddrWidth-1:0]    size_hi,
   input  logic [AxiAddrWidth-1:0] base,
   input  logic                    start_ready,
   input  logic                    done_valid,
   output logic                    start_valid,
   output logic                    done_ready,
   output logic [AddrWidth-1:0]    data_ptr,
   output logic [AddrWidth-1:0]    data_size,
   output logic [AxiAddrWidth-1:0] axi_offset,
   output logic [1:0]              pend_clr,
   output logic                    idle
);

   localparam int HD = half_depth(AddrWidth);

   disp_state_t              state, state_nxt;
   logic                     disp_half;
   logic [AxiAddrWidth-1:0]  written;
   logic [AddrWidth-1:0]     cur_size;
   logic                     done_fire;

   assign cur_size  = disp_half ? size_hi : size_lo;
   assign done_fire = (state == D_WAIT) && done_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= D_IDLE;
      else        state <= state_nxt;
   end

   // Halves alternate strictly, so toggling disp_half preserves seal order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_half <= 1'b0;
         written   <= '0;
      end else begin
         if (cfg_load)       written <= '0;
         else if (done_fire) written <= written + AxiAddrWidth'(cur_size);
         if (done_fire) disp_half <= ~disp_half;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         D_IDLE:  if (pend[disp_half]) state_nxt = D_START;
         D_START: if (start_ready)     state_nxt = D_WAIT;
         D_WAIT:  if (done_valid)      state_nxt = D_IDLE;
         default:                      state_nxt = D_IDLE;
      endcase
   end

   always_comb begin
      start_valid = 1'b0;
      done_ready  = 1'b0;
      data_ptr    = '0;
      data_size   = '0;
      axi_offset  = '0;
      pend_clr    = 2'b00;
      idle        = (state == D_IDLE);
      case (state)
         D_START: begin
            start_valid = 1'b1;
            data_ptr    = disp_half ? AddrWidth'(HD) : '0;
            data_size   = cur_size;
            axi_offset  = base + written * AxiAddrWidth'(WordBytes);
         end
         D_WAIT: begin
            done_ready          = 1'b1;
            pend_clr[disp_half] = done_valid;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/trace_chunk_sequencer.sv
// Ping-pong trace buffer filler feeding the AXI burst write engine.
// Define TRACE_DROP_COUNT_EN to discard (and count) words instead of back-pressuring.
module trace_chunk_sequencer
   import trace_pkg::*;
#(
   parameter int BufferDataWidth = 32,
   parameter int BufferAddrWidth = 10,
   parameter int AXIAddrWidth    = 64,
   parameter int AXIDataWidth    = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [AXIAddrWidth-1:0]    cfg_base,
   input  logic [AXIAddrWidth-1:0]    cfg_words,
   input  logic                       trace_valid,
   output logic                       trace_ready,
   input  logic [BufferDataWidth-1:0] trace_data,
   input  logic                       flush,
   output logic                       flush_done,
   output logic                       region_full,
   output logic [BufferAddrWidth-1:0] buffer_addr,
   output logic [BufferDataWidth-1:0] buffer_data,
   output logic                       buffer_ce,
   output logic                       buffer_we,
   output logic                       start_valid,
   input  logic                       start_ready,
   output logic [BufferAddrWidth-1:0] data_ptr,
   output logic [BufferAddrWidth-1:0] data_size,
   output logic [AXIAddrWidth-1:0]    axi_offset,
   input  logic                       done_valid,
   output logic                       done_ready
`ifdef TRACE_DROP_COUNT_EN
   ,
   output logic [31:0]                drop_count
`endif
);

   localparam int HD = half_depth(BufferAddrWidth);

   logic                       fill_half;
   logic [BufferAddrWidth-1:0] fill_count, cnt_next, seal_count;
   logic [BufferAddrWidth-1:0] size_lo, size_hi;
   logic [1:0]                 pend, pend_set, pend_clr;
   logic [AXIAddrWidth-1:0]    base_q, cap_q, reserved;
   logic                       loaded, region_full_q;
   logic                       can_accept, accept, seal_acc, seal_flush, seal;
   logic                       quiescent, disp_idle, cfg_fire;

   assign can_accept = loaded && !pend[fill_half] && !region_full_q;
   assign accept     = trace_valid && can_accept;
   assign cnt_next   = fill_count + BufferAddrWidth'(1);
   assign seal_acc   = accept && ((cnt_next == BufferAddrWidth'(HD)) ||
                                  (reserved + AXIAddrWidth'(cnt_next) == cap_q));
   assign seal_flush = flush && !accept && (fill_count != '0) && !pend[fill_half];
   assign seal       = seal_acc || seal_flush;
   assign seal_count = accept ? cnt_next : fill_count;
   assign pend_set   = seal ? (fill_half ? 2'b10 : 2'b01) : 2'b00;

   // Gating with the reset level keeps cfg_ready low while reset is held.
   assign quiescent  = (pend == 2'b00) && (fill_count == '0) && disp_idle;
   assign cfg_ready  = quiescent && reset;
   assign cfg_fire   = cfg_valid && cfg_ready;
   assign flush_done = quiescent && loaded;
   assign region_full = region_full_q;

`ifdef TRACE_DROP_COUNT_EN
   assign trace_ready = 1'b1;
`else
   assign trace_ready = can_accept;
`endif

   assign buffer_ce   = accept;
   assign buffer_we   = accept;
   assign buffer_addr = accept ? {fill_half, fill_count[BufferAddrWidth-2:0]} : '0;
   assign buffer_data = accept ? trace_data : '0;

   // Sealing hands the current half to the dispatcher and flips to the other one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_half     <= 1'b0;
         fill_count    <= '0;
         size_lo       <= '0;
         size_hi       <= '0;
         pend          <= 2'b00;
         base_q        <= '0;
         cap_q         <= '0;
         reserved      <= '0;
         loaded        <= 1'b0;
         region_full_q <= 1'b0;
      end else begin
         pend <= (pend | pend_set) & ~pend_clr;
         if (seal) begin
            if (fill_half) size_hi <= seal_count;
            else           size_lo <= seal_count;
            reserved      <= reserved + AXIAddrWidth'(seal_count);
            region_full_q <= (reserved + AXIAddrWidth'(seal_count) == cap_q);
            fill_half     <= ~fill_half;
            fill_count    <= '0;
         end else if (accept) begin
            fill_count <= cnt_next;
         end
         if (cfg_fire) begin
            base_q        <= cfg_base;
            cap_q         <= cfg_words;
            reserved      <= '0;
            region_full_q <= (cfg_words == '0);
            loaded        <= 1'b1;
         end
      end
   end

`ifdef TRACE_DROP_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                      drop_count <= '0;
      else if (cfg_fire)                               drop_count <= '0;
      else if (trace_valid && !can_accept && drop_count != '1) drop_count <= drop_count + 32'd1;
   end
`endif

   trace_chunk_dispatch #(
      .AddrWidth    (BufferAddrWidth),
      .AxiAddrWidth (AXIAddrWidth),
      .WordBytes    (AXIDataWidth / 8)
   ) u_dispatch (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_fire),
      .pend        (pend),
      .size_lo     (size_lo),
      .size_hi     (size_hi),
      .base        (base_q),
      .start_ready (start_ready),
      .done_valid  (done_valid),
      .start_valid (start_valid),
      .done_ready  (done_ready),
      .data_ptr    (data_ptr),
      .data_size   (data_size),
      .axi_offset  (axi_offset),
      .pend_clr    (pend_clr),
      .idle        (disp_idle)
   );

endmodule

// File: tb/tb_trace_chunk_sequencer.sv
// Scoreboard bench for trace_chunk_sequencer with a half depth of 8 words.
module tb_trace_chunk_sequencer;

   localparam int HD = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_valid, cfg_ready;
   logic [63:0] cfg_base, cfg_words;
   logic        trace_valid, trace_ready;
   logic [31:0] trace_data;
   logic        flush, flush_done, region_full;
   logic [3:0]  buffer_addr;
   logic [31:0] buffer_data;
   logic        buffer_ce, buffer_we;
   logic        start_valid, start_ready;
   logic [3:0]  data_ptr, data_size;
   logic [63:0] axi_offset;
   logic        done_valid, done_ready;
`ifdef TRACE_DROP_COUNT_EN
   logic [31:0] drop_count;
`endif

   typedef struct {
      int          ptr;
      int          size;
      logic [63:0] off;
   } job_t;

   job_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          jobs_seen = 0;
   int          jobs_pushed = 0;
   int          done_cyc = 0;
   int          acc_cyc = 0;
   logic        hold_done = 1'b0;
   int          m_half = 0;
   int          m_count = 0;
   longint      m_reserved = 0;
   longint      m_cap = 0;
   logic [63:0] m_base = '0;

   trace_chunk_sequencer #(
      .BufferDataWidth (32),
      .BufferAddrWidth (4),
      .AXIAddrWidth    (64),
      .AXIDataWidth    (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_base    (cfg_base),
      .cfg_words   (cfg_words),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_data  (trace_data),
      .flush       (flush),
      .flush_done  (flush_done),
      .region_full (region_full),
      .buffer_addr (buffer_addr),
      .buffer_data (buffer_data),
      .buffer_ce   (buffer_ce),
      .buffer_we   (buffer_we),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .data_ptr    (data_ptr),
      .data_size   (data_size),
      .axi_offset  (axi_offset),
      .done_valid  (done_valid),
      .done_ready  (done_ready)
`ifdef TRACE_DROP_COUNT_EN
      ,
      .drop_count  (drop_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic push_seal();
      job_t j;
      j.ptr  = m_half * HD;
      j.size = m_count;
      j.off  = m_base + 64'(m_reserved * 4);
      sb.push_back(j);
      jobs_pushed++;
      m_reserved += m_count;
      m_half     ^= 1;
      m_count    = 0;
   endtask

   // Engine model: accepts every job at once, completes it unless held.
   initial begin
      job_t j;
      start_ready = 1'b1;
      done_valid  = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            done_valid = 1'b0;
         end else begin
            if (done_valid) done_cyc = cyc;
            if (start_valid) begin
               jobs_seen++;
               if (sb.size() == 0) begin
                  check_output("sb_underflow", 64'd1, 64'd0);
               end else begin
                  j = sb.pop_front();
                  check_output("job_ptr", 64'(data_ptr), 64'(j.ptr));
                  check_output("job_size", 64'(data_size), 64'(j.size));
                  check_output("job_offset", axi_offset, j.off);
               end
            end
            done_valid = done_ready && !hold_done;
         end
      end
   end

   task automatic wait_quiescent();
      int n = 0;
      @(negedge clk); #1;
      while (!cfg_ready && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      check_output("quiescent", 64'(cfg_ready), 64'd1);
   endtask

   task automatic apply_cfg(input logic [63:0] base, input logic [63:0] words);
      wait_quiescent();
      cfg_valid  = 1'b1;
      cfg_base   = base;
      cfg_words  = words;
      @(posedge clk); #1;
      cfg_valid  = 1'b0;
      m_base     = base;
      m_cap      = longint'(words);
      m_reserved = 0;
   endtask

   task automatic apply_stimulus(input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      trace_valid = 1'b1;
      trace_data  = d;
      #1;
      while (!trace_ready && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      if (!trace_ready) begin
         check_output("word_timeout", 64'd0, 64'd1);
         trace_valid = 1'b0;
         return;
      end
      check_output("buf_we", 64'(buffer_we), 64'd1);
      check_output("buf_addr", 64'(buffer_addr), 64'(m_half * HD + m_count));
      check_output("buf_data", 64'(buffer_data), 64'(d));
      acc_cyc = cyc + 1;
      @(posedge clk);
      m_count++;
      if (m_count == HD || m_reserved + m_count == m_cap) push_seal();
      #1 trace_valid = 1'b0;
   endtask

   task automatic apply_flush();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      if (m_count > 0) push_seal();
      #1 flush = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b0;
      cfg_valid = 1'b0; cfg_base = '0; cfg_words = '0;
      trace_valid = 1'b0; trace_data = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_output("rst_start_valid", 64'(start_valid), 64'd0);
      check_output("rst_done_ready", 64'(done_ready), 64'd0);
      check_output("rst_cfg_ready", 64'(cfg_ready), 64'd0);
      check_output("rst_flush_done", 64'(flush_done), 64'd0);
      check_output("rst_region_full", 64'(region_full), 64'd0);
      check_output("rst_buffer_we", 64'(buffer_we), 64'd0);
      check_output("rst_axi_offset", axi_offset, 64'd0);
`ifndef TRACE_DROP_COUNT_EN
      check_output("rst_trace_ready", 64'(trace_ready), 64'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_output("idle_cfg_ready", 64'(cfg_ready), 64'd1);
      check_output("idle_flush_done", 64'(flush_done), 64'd0);

      // Two full halves: ptr 0 @0x1000 then ptr 8 @0x1020.
      apply_cfg(64'h1000, 64'd64);
      for (int i = 0; i < 16; i++) apply_stimulus(32'hA000_0000 + 32'(i));
      wait_quiescent();

      // Partial half sealed by flush.
      for (int i = 0; i < 5; i++) apply_stimulus(32'hB000_0000 + 32'(i));
      apply_flush();
      wait_quiescent();
      check_output("flush_done", 64'(flush_done), 64'd1);

`ifndef TRACE_DROP_COUNT_EN
      // Back-pressure while both halves are pending.
      hold_done = 1'b1;
      for (int i = 0; i < 16; i++) apply_stimulus(32'hC000_0000 + 32'(i));
      fork
         apply_stimulus(32'hC000_0010);
         begin
            repeat (4) @(negedge clk);
            #1;
            check_output("bp_ready", 64'(trace_ready), 64'd0);
            check_output("bp_we", 64'(buffer_we), 64'd0);
            hold_done = 1'b0;
         end
      join
      check_output("late_accept_cycle", 64'(acc_cyc - done_cyc), 64'd1);
      apply_flush();
      wait_quiescent();
`endif

      // Region capacity of 12 words: jobs of 8 and 4.
      apply_cfg(64'h1000, 64'd12);
      for (int i = 0; i < 12; i++) apply_stimulus(32'hD000_0000 + 32'(i));
      @(negedge clk);
      trace_valid = 1'b1;
      #1;
      check_output("full_flag", 64'(region_full), 64'd1);
      check_output("full_we", 64'(buffer_we), 64'd0);
`ifndef TRACE_DROP_COUNT_EN
      check_output("full_ready", 64'(trace_ready), 64'd0);
`endif
      trace_valid = 1'b0;
      wait_quiescent();
      check_output("full_flush_done", 64'(flush_done), 64'd1);

      apply_cfg(64'h2000, 64'd0);
      @(negedge clk); #1;
      check_output("zero_cap_full", 64'(region_full), 64'd1);

      // Reset while the engine is in the middle of a job.
      apply_cfg(64'h1000, 64'd64);
      check_output("cfg_clears_full", 64'(region_full), 64'd0);
      hold_done = 1'b1;
      for (int i = 0; i < 8; i++) apply_stimulus(32'hE000_0000 + 32'(i));
      n = 0;
      while (!done_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check_output("mid_done_ready", 64'(done_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("mid_rst_start_valid", 64'(start_valid), 64'd0);
      check_output("mid_rst_done_ready", 64'(done_ready), 64'd0);
      check_output("mid_rst_flush_done", 64'(flush_done), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      hold_done = 1'b0;
      m_half = 0;
      m_count = 0;
      #1;
      check_output("post_rst_cfg_ready", 64'(cfg_ready), 64'd1);
      check_output("post_rst_flush_done", 64'(flush_done), 64'd0);

`ifdef TRACE_DROP_COUNT_EN
      apply_cfg(64'h1000, 64'd64);
      hold_done = 1'b1;
      for (int i = 0; i < 16; i++) apply_stimulus(32'hF000_0000 + 32'(i));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         trace_valid = 1'b1;
         #1;
         check_output("drop_we", 64'(buffer_we), 64'd0);
         @(posedge clk); #1;
         trace_valid = 1'b0;
      end
      @(negedge clk); #1;
      check_output("drop_count", 64'(drop_count), 64'd3);
      hold_done = 1'b0;
      wait_quiescent();
`endif

      check_output("jobs_issued", 64'(jobs_seen), 64'(jobs_pushed));
      check_output("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
